multicycle_controller: RTL and testbench

- Moore-style main control FSM for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over a shared ALU and a single memory port.
- Drives ALUOp into the ALU function decoder, plus all datapath mux selects and write enables.
- Stalls on a memory-ready handshake. Traps on unsupported opcodes.

---
 rtl/multicycle_controller.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Optional retired-instruction counter enabled by defining MULTICYCLE_CTRL_INSTRET_EN.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  input  logic             branch_cond,
  output logic             mem_req,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEMADR    = 4'd2;
  localparam logic [3:0] S_MEMREAD   = 4'd3;
  localparam logic [3:0] S_MEMWB     = 4'd4;
  localparam logic [3:0] S_MEMWRITE  = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_EXEC_JALR = 4'd8;
  localparam logic [3:0] S_LUI       = 4'd9;
  localparam logic [3:0] S_ALUWB     = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JAL       = 4'd12;
  localparam logic [3:0] S_TRAP      = 4'd13;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       r_is_store;

  // Load/store direction is captured in DECODE so later op changes cannot steer MEMADR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RESET_STATE;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_is_store <= (op == OP_SW);
    end
  end

  always_comb begin
    w_next = S_TRAP;
    case (r_state)
      S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC_R;
          OP_I:         w_next = S_EXEC_I;
          OP_BR:        w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          OP_JALR:      w_next = S_EXEC_JALR;
          OP_LUI:       w_next = S_LUI;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR:    w_next = r_is_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:   w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:     w_next = S_FETCH;
      S_MEMWRITE:  w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC_R:    w_next = S_ALUWB;
      S_EXEC_I:    w_next = S_ALUWB;
      S_EXEC_JALR: w_next = S_JAL;
      S_LUI:       w_next = S_ALUWB;
      S_ALUWB:     w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JAL:       w_next = S_ALUWB;
      S_TRAP:      w_next = S_TRAP;
      default:     w_next = S_TRAP;
    endcase
  end

  logic       w_mem_req;
  logic       w_pc_write;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_illegal;

  always_comb begin
    w_mem_req   = 1'b0;
    w_pc_write  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        adr_src   = 1'b1;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_EXEC_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_ALUWB:  w_reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        w_pc_write = branch_cond;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        w_pc_write = 1'b1;
      end
      S_TRAP:  w_illegal = 1'b1;
      default: ;
    endcase
  end

  // Gate strobes with rst so nothing pulses on or after the reset assertion edge.
  assign mem_req   = w_mem_req   & ~rst;
  assign pc_write  = w_pc_write  & ~rst;
  assign mem_write = w_mem_write & ~rst;
  assign ir_write  = w_ir_write  & ~rst;
  assign reg_write = w_reg_write & ~rst;
  assign illegal   = w_illegal   & ~rst;

  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_SW:   imm_src = 3'b001;
      OP_BR:   imm_src = 3'b010;
      OP_JAL:  imm_src = 3'b011;
      OP_LUI:  imm_src = 3'b100;
      default: imm_src = 3'b000;
    endcase
  end

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;

  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_BRANCH) || ((r_state == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_instret <= '0;
    else if (w_retire)
      r_instret <= r_instret + CNT_W'(1);
  end

  assign instret = r_instret;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench with scoreboard queue; a negedge monitor pops and compares each cycle.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op = 7'b0;
  logic        mem_ready = 1'b1;
  logic        branch_cond = 1'b0;
  logic        mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0]  imm_src;
  logic [31:0] instret;

  multicycle_controller #(.RESET_STATE(4'd0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready), .branch_cond(branch_cond),
    .mem_req(mem_req), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111;
  localparam logic [6:0] BAD = 7'b0000000;

  logic [49:0] q_exp[$];
  string       q_tag[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_ret = 0;

  // {mem_req,pc_write,adr_src,mem_write,ir_write,reg_write,result_src,alu_src_a,alu_src_b,alu_op,imm_src,illegal}
  function automatic logic [17:0] v(logic mq, logic pw, logic ad, logic mw, logic iw, logic rw,
                                    logic [1:0] rs, logic [1:0] a, logic [1:0] b, logic [1:0] ao,
                                    logic [2:0] im, logic il);
    return {mq, pw, ad, mw, iw, rw, rs, a, b, ao, im, il};
  endfunction

  function automatic logic [17:0] vRST(logic [2:0] i); return v(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,i,0); endfunction
  function automatic logic [17:0] vF(logic mr, logic [2:0] i); return v(1,mr,0,0,mr,0,2'b10,2'b00,2'b10,2'b00,i,0); endfunction
  function automatic logic [17:0] vDEC(logic [2:0] i); return v(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,i,0); endfunction
  function automatic logic [17:0] vMA(logic [2:0] i); return v(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,i,0); endfunction
  function automatic logic [17:0] vMR(logic [2:0] i); return v(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,i,0); endfunction
  function automatic logic [17:0] vMWB(logic [2:0] i); return v(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,i,0); endfunction
  function automatic logic [17:0] vMW(logic [2:0] i); return v(1,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,i,0); endfunction
  function automatic logic [17:0] vER(logic [2:0] i); return v(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,i,0); endfunction
  function automatic logic [17:0] vEI(logic [2:0] i); return v(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,i,0); endfunction
  function automatic logic [17:0] vEJ(logic [2:0] i); return v(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b11,i,0); endfunction
  function automatic logic [17:0] vLUI(logic [2:0] i); return v(0,0,0,0,0,0,2'b00,2'b11,2'b01,2'b00,i,0); endfunction
  function automatic logic [17:0] vAWB(logic [2:0] i); return v(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,i,0); endfunction
  function automatic logic [17:0] vBR(logic bc, logic [2:0] i); return v(0,bc,0,0,0,0,2'b00,2'b10,2'b00,2'b01,i,0); endfunction
  function automatic logic [17:0] vJAL(logic [2:0] i); return v(0,1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,i,0); endfunction
  function automatic logic [17:0] vTRAP(logic [2:0] i); return v(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,i,1); endfunction

  // One clock: drive inputs just after the edge, queue what the DUT must show this cycle.
  // inc marks that the edge opening this cycle retired an instruction.
  task automatic cyc(input logic r, input logic [6:0] o, input logic mr, input logic bc,
                     input logic inc, input logic [17:0] e, input string tag);
    logic [31:0] er;
    @(posedge clk);
    #1;
    rst = r; op = o; mem_ready = mr; branch_cond = bc;
    if (r) exp_ret = 0;
    else if (inc) exp_ret++;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    er = 32'(exp_ret);
`else
    er = 32'd0;
`endif
    q_exp.push_back({e, er});
    q_tag.push_back(tag);
  endtask

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      logic [49:0] exp_v, act_v;
      string t;
      exp_v = q_exp.pop_front();
      t = q_tag.pop_front();
      act_v = {mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, illegal, instret};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got ctl=%b instret=%0d expected ctl=%b instret=%0d",
                 t, act_v[49:32], act_v[31:0], exp_v[49:32], exp_v[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(1, BAD, 1, 1, 0, vRST(3'b000), "reset0");
    cyc(1, BAD, 1, 1, 0, vRST(3'b000), "reset1");
    // R-type
    cyc(0, RT, 1, 0, 0, vF(1, 3'b000), "r_fetch");
    cyc(0, RT, 1, 0, 0, vDEC(3'b000), "r_dec");
    cyc(0, RT, 1, 0, 0, vER(3'b000), "r_exec");
    cyc(0, RT, 1, 0, 0, vAWB(3'b000), "r_wb");
    // I-type
    cyc(0, IT, 1, 0, 1, vF(1, 3'b000), "i_fetch");
    cyc(0, IT, 1, 0, 0, vDEC(3'b000), "i_dec");
    cyc(0, IT, 1, 0, 0, vEI(3'b000), "i_exec");
    cyc(0, IT, 1, 0, 0, vAWB(3'b000), "i_wb");
    // lw: fetch stall, mem_ready ignored in DECODE/MEMADR, op change in MEMADR ignored, read stall
    cyc(0, LW, 0, 0, 1, vF(0, 3'b000), "lw_fetch_stall");
    cyc(0, LW, 1, 0, 0, vF(1, 3'b000), "lw_fetch");
    cyc(0, LW, 0, 0, 0, vDEC(3'b000), "lw_dec");
    cyc(0, SW, 0, 0, 0, vMA(3'b001), "lw_memadr");
    cyc(0, LW, 0, 0, 0, vMR(3'b000), "lw_rd_stall0");
    cyc(0, LW, 0, 0, 0, vMR(3'b000), "lw_rd_stall1");
    cyc(0, LW, 0, 0, 0, vMR(3'b000), "lw_rd_stall2");
    cyc(0, LW, 1, 0, 0, vMR(3'b000), "lw_rd_done");
    cyc(0, LW, 1, 0, 0, vMWB(3'b000), "lw_memwb");
    // sw with one write stall
    cyc(0, SW, 1, 0, 1, vF(1, 3'b001), "sw_fetch");
    cyc(0, SW, 1, 0, 0, vDEC(3'b001), "sw_dec");
    cyc(0, SW, 1, 0, 0, vMA(3'b001), "sw_memadr");
    cyc(0, SW, 0, 0, 0, vMW(3'b001), "sw_wr_stall");
    cyc(0, SW, 1, 0, 0, vMW(3'b001), "sw_wr_done");
    // branch taken, then not taken; branch_cond ignored outside BRANCH
    cyc(0, BR, 1, 1, 1, vF(1, 3'b010), "bt_fetch");
    cyc(0, BR, 1, 1, 0, vDEC(3'b010), "bt_dec");
    cyc(0, BR, 1, 1, 0, vBR(1, 3'b010), "bt_branch");
    cyc(0, BR, 1, 0, 1, vF(1, 3'b010), "bn_fetch");
    cyc(0, BR, 1, 0, 0, vDEC(3'b010), "bn_dec");
    cyc(0, BR, 1, 0, 0, vBR(0, 3'b010), "bn_branch");
    // jal
    cyc(0, JL, 1, 1, 1, vF(1, 3'b011), "jal_fetch");
    cyc(0, JL, 1, 1, 0, vDEC(3'b011), "jal_dec");
    cyc(0, JL, 1, 1, 0, vJAL(3'b011), "jal_jal");
    cyc(0, JL, 1, 1, 0, vAWB(3'b011), "jal_wb");
    // jalr
    cyc(0, JR, 1, 0, 1, vF(1, 3'b000), "jalr_fetch");
    cyc(0, JR, 1, 0, 0, vDEC(3'b000), "jalr_dec");
    cyc(0, JR, 1, 0, 0, vEJ(3'b000), "jalr_exec");
    cyc(0, JR, 1, 0, 0, vJAL(3'b000), "jalr_jal");
    cyc(0, JR, 1, 0, 0, vAWB(3'b000), "jalr_wb");
    // lui
    cyc(0, LU, 1, 0, 1, vF(1, 3'b100), "lui_fetch");
    cyc(0, LU, 1, 0, 0, vDEC(3'b100), "lui_dec");
    cyc(0, LU, 1, 0, 0, vLUI(3'b100), "lui_exec");
    cyc(0, LU, 1, 0, 0, vAWB(3'b100), "lui_wb");
    // reset asserted mid-MEMWRITE with mem_ready high
    cyc(0, SW, 1, 0, 1, vF(1, 3'b001), "rsw_fetch");
    cyc(0, SW, 1, 0, 0, vDEC(3'b001), "rsw_dec");
    cyc(0, SW, 0, 0, 0, vMA(3'b001), "rsw_memadr");
    cyc(0, SW, 0, 0, 0, vMW(3'b001), "rsw_memwrite");
    cyc(1, SW, 1, 0, 0, vRST(3'b001), "rsw_abort");
    cyc(1, SW, 1, 0, 0, vRST(3'b001), "rsw_hold");
    cyc(0, SW, 1, 0, 0, vF(1, 3'b001), "rsw_release");
    // illegal op traps; stays through mem_ready/op/branch_cond activity
    cyc(0, BAD, 1, 0, 0, vDEC(3'b000), "ill_dec");
    for (int k = 0; k < 11; k++) begin
      logic [6:0] o;
      logic [2:0] im;
      o  = k[0] ? LU : BAD;
      im = k[0] ? 3'b100 : 3'b000;
      cyc(0, o, k[1], k[2], 0, vTRAP(im), $sformatf("trap_hold%0d", k));
    end
    cyc(1, BAD, 1, 0, 0, vRST(3'b000), "trap_reset");
    cyc(0, RT, 1, 0, 0, vF(1, 3'b000), "post_trap_fetch");
    cyc(0, RT, 1, 0, 0, vDEC(3'b000), "post_trap_dec");
    @(negedge clk);
    @(negedge clk);
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
